// File: rtl/regfile_wr_arb_pkg.sv
// regfile_wr_arb_pkg
//   Shared types and constants for the register-file write-port controller.
//   arb_state_t : controller state (INIT = clear sequencer, ARB = arbitration)
//   NUM_REGS    : register-file depth
//   REG_AW      : register index width
//   NUM_REQ     : number of writeback requesters
package regfile_wr_arb_pkg;

  typedef enum logic {
    INIT = 1'b0,
    ARB  = 1'b1
  } arb_state_t;

  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned REG_AW   = 4;
  localparam int unsigned NUM_REQ  = 4;

endpackage

// File: rtl/regfile_wr_arb_arb.sv
// rr_arb4
//   Combinational 4-way round-robin picker. Searches req upward starting at
//   ptr, wrapping 3->0, and returns the first asserted requester.
//   Ports:
//     req [3:0] in  : request vector
//     ptr [1:0] in  : highest-priority index for this cycle
//     gnt [3:0] out : one-hot winner, 0 when no request
//     idx [1:0] out : binary index of winner (0 when no request)
//     any       out : at least one request asserted
module rr_arb4
  import regfile_wr_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [1:0]         idx,
  output logic               any
);

  logic [1:0] w_pos;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    any   = 1'b0;
    w_pos = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      // 2-bit add wraps naturally from 3 back to 0
      w_pos = ptr + 2'(j);
      if (!any && req[w_pos]) begin
        any        = 1'b1;
        idx        = w_pos;
        gnt[w_pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wr_arb.sv
// regfile_wr_arb
//   Write-port controller for the 16-entry register file. Round-robin shares
//   the single write port between four requesters and registers the port's
//   enable/select/data. With REGFILE_WR_ARB_INIT_EN defined, every reset is
//   followed by a 16-cycle clear of all registers (busy high meanwhile);
//   without it the controller starts directly in arbitration.
//   Ports:
//     clk            in  : rising-edge clock
//     reset_n        in  : asynchronous active-low reset
//     req[NREQ]      in  : per-requester valid
//     req_addr[4N]   in  : packed register index, requester i at [4i+3:4i]
//     req_data[DW*N] in  : packed write data
//     gnt[NREQ]      out : combinational one-hot ready
//     wr_en          out : register-file write enable (decoder En)
//     wr_sel[4]      out : register index (decoder sel)
//     wr_data[DW]    out : write data
//     busy           out : init clear sequence in progress
module regfile_wr_arb
  import regfile_wr_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*4-1:0]    req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      gnt,
  output logic                 wr_en,
  output logic [REG_AW-1:0]    wr_sel,
  output logic [DW-1:0]        wr_data,
  output logic                 busy
);

  arb_state_t        r_state, w_state_nxt;
  logic [1:0]        r_ptr, w_ptr_nxt;
  logic              r_wr_en, w_wr_en_nxt;
  logic [REG_AW-1:0] r_wr_sel, w_wr_sel_nxt;
  logic [DW-1:0]     r_wr_data, w_wr_data_nxt;

  logic [NREQ-1:0]   w_arb_gnt;
  logic [1:0]        w_arb_idx;
  logic              w_arb_any;
  logic              w_in_arb;
  logic              w_xfer;
  logic [REG_AW-1:0] w_win_addr;
  logic [DW-1:0]     w_win_data;

`ifdef REGFILE_WR_ARB_INIT_EN
  logic [REG_AW-1:0] r_cnt, w_cnt_nxt;
`endif

  rr_arb4 u_arb (
    .req (req),
    .ptr (r_ptr),
    .gnt (w_arb_gnt),
    .idx (w_arb_idx),
    .any (w_arb_any)
  );

  // Grant is gated only by state, never by address/data inputs.
  assign w_in_arb = (r_state == ARB);
  assign gnt      = w_in_arb ? w_arb_gnt : '0;
  assign w_xfer   = w_in_arb & w_arb_any;

  always_comb begin
    w_win_addr = '0;
    w_win_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_arb_idx == 2'(i)) begin
        w_win_addr = req_addr[i*REG_AW +: REG_AW];
        w_win_data = req_data[i*DW +: DW];
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_wr_en_nxt   = 1'b0;
    w_wr_sel_nxt  = r_wr_sel;
    w_wr_data_nxt = r_wr_data;
`ifdef REGFILE_WR_ARB_INIT_EN
    w_cnt_nxt     = r_cnt;
`endif
    unique case (r_state)
      INIT: begin
`ifdef REGFILE_WR_ARB_INIT_EN
        w_wr_en_nxt   = 1'b1;
        w_wr_sel_nxt  = r_cnt;
        w_wr_data_nxt = '0;
        w_cnt_nxt     = r_cnt + 4'd1;
        if (r_cnt == REG_AW'(NUM_REGS - 1)) w_state_nxt = ARB;
`else
        w_state_nxt = ARB;
`endif
      end
      ARB: begin
        if (w_xfer) begin
          w_wr_en_nxt   = 1'b1;
          w_wr_sel_nxt  = w_win_addr;
          w_wr_data_nxt = w_win_data;
          w_ptr_nxt     = w_arb_idx + 2'd1;
        end
      end
      default: w_state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
`ifdef REGFILE_WR_ARB_INIT_EN
      r_state <= INIT;
      r_cnt   <= '0;
`else
      r_state <= ARB;
`endif
      r_ptr     <= '0;
      r_wr_en   <= 1'b0;
      r_wr_sel  <= '0;
      r_wr_data <= '0;
    end else begin
      r_state   <= w_state_nxt;
`ifdef REGFILE_WR_ARB_INIT_EN
      r_cnt     <= w_cnt_nxt;
`endif
      r_ptr     <= w_ptr_nxt;
      r_wr_en   <= w_wr_en_nxt;
      r_wr_sel  <= w_wr_sel_nxt;
      r_wr_data <= w_wr_data_nxt;
    end
  end

  assign wr_en   = r_wr_en;
  assign wr_sel  = r_wr_sel;
  assign wr_data = r_wr_data;

`ifdef REGFILE_WR_ARB_INIT_EN
  assign busy = (r_state == INIT);
`else
  assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wr_arb.sv
// tb_regfile_wr_arb
//   Directed-vector bench for regfile_wr_arb. Init-sequence scenarios are
//   compiled only when REGFILE_WR_ARB_INIT_EN is defined.
module tb_regfile_wr_arb;

  logic         clk;
  logic         reset_n;
  logic [3:0]   req;
  logic [15:0]  req_addr;
  logic [127:0] req_data;
  logic [3:0]   gnt;
  logic         wr_en;
  logic [3:0]   wr_sel;
  logic [31:0]  wr_data;
  logic         busy;

  int n_vec = 0;
  int n_err = 0;

`ifdef REGFILE_WR_ARB_INIT_EN
  localparam logic EXP_RST_BUSY = 1'b1;
`else
  localparam logic EXP_RST_BUSY = 1'b0;
`endif

  regfile_wr_arb #(.NREQ(4), .DW(32)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req),
    .req_addr (req_addr),
    .req_data (req_data),
    .gnt      (gnt),
    .wr_en    (wr_en),
    .wr_sel   (wr_sel),
    .wr_data  (wr_data),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic set_lane(input int i, input logic [3:0] a, input logic [31:0] d);
    req_addr[i*4 +: 4]   = a;
    req_data[i*32 +: 32] = d;
  endtask

  // Reset, release, and (with init enabled) let the clear sequence finish.
  // Leaves the bench at posedge+1 with ptr=0 and the DUT in ARB.
  task automatic do_reset();
    req     = '0;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
`ifdef REGFILE_WR_ARB_INIT_EN
    repeat (16) @(posedge clk);
    #1;
`endif
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    req      = '0;
    req_addr = '0;
    req_data = '0;
    #2;
    n_vec++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL rst_wr_en: got %0b expected 0", wr_en); end
    n_vec++; if (wr_sel !== 4'd0) begin n_err++; $display("FAIL rst_wr_sel: got %0h expected 0", wr_sel); end
    n_vec++; if (wr_data !== 32'd0) begin n_err++; $display("FAIL rst_wr_data: got %0h expected 0", wr_data); end
    n_vec++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL rst_gnt: got %b expected 0000", gnt); end
    n_vec++; if (busy !== EXP_RST_BUSY) begin n_err++; $display("FAIL rst_busy: got %0b expected %0b", busy, EXP_RST_BUSY); end
  endtask

`ifdef REGFILE_WR_ARB_INIT_EN
  task automatic test_init_seq();
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    req = 4'hF;  // must be ignored while clearing
    for (int c = 0; c < 16; c++) begin
      #1;
      n_vec++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL init_gnt[%0d]: got %b expected 0000", c, gnt); end
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL init_busy[%0d]: got %0b expected 1", c, busy); end
      @(posedge clk); #1;
      n_vec++; if (wr_en !== 1'b1) begin n_err++; $display("FAIL init_wr_en[%0d]: got %0b expected 1", c, wr_en); end
      n_vec++; if (wr_sel !== 4'(c)) begin n_err++; $display("FAIL init_wr_sel[%0d]: got %0d expected %0d", c, wr_sel, c); end
      n_vec++; if (wr_data !== 32'd0) begin n_err++; $display("FAIL init_wr_data[%0d]: got %0h expected 0", c, wr_data); end
    end
    req = '0;
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL init_done_busy: got %0b expected 0", busy); end
    @(posedge clk); #1;
    n_vec++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL init_idle_wr_en: got %0b expected 0", wr_en); end
  endtask

  task automatic test_reset_mid_init();
    req     = '0;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    n_vec++; if (wr_sel !== 4'd6) begin n_err++; $display("FAIL mid_pre_sel: got %0d expected 6", wr_sel); end
    reset_n = 1'b0;
    #1;
    n_vec++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL mid_rst_wr_en: got %0b expected 0", wr_en); end
    n_vec++; if (wr_sel !== 4'd0) begin n_err++; $display("FAIL mid_rst_wr_sel: got %0d expected 0", wr_sel); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_rst_busy: got %0b expected 1", busy); end
    #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (wr_en !== 1'b1) begin n_err++; $display("FAIL mid_restart_en: got %0b expected 1", wr_en); end
    n_vec++; if (wr_sel !== 4'd0) begin n_err++; $display("FAIL mid_restart_sel: got %0d expected 0", wr_sel); end
    repeat (15) @(posedge clk);
    #1;
    n_vec++; if (wr_sel !== 4'd15) begin n_err++; $display("FAIL mid_last_sel: got %0d expected 15", wr_sel); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_done_busy: got %0b expected 0", busy); end
  endtask
`endif

  task automatic test_first_cycle();
    do_reset();
    set_lane(2, 4'd15, 32'hCAFE_0015);
    req = 4'b0100;
    #1;
    n_vec++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL first_gnt: got %b expected 0100", gnt); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL first_busy: got %0b expected 0", busy); end
    @(posedge clk); #1;
    req = '0;
    n_vec++; if (wr_en !== 1'b1) begin n_err++; $display("FAIL first_wr_en: got %0b expected 1", wr_en); end
    n_vec++; if (wr_sel !== 4'd15) begin n_err++; $display("FAIL first_wr_sel: got %0d expected 15", wr_sel); end
    n_vec++; if (wr_data !== 32'hCAFE_0015) begin n_err++; $display("FAIL first_wr_data: got %0h expected cafe0015", wr_data); end
  endtask

  task automatic test_single();
    do_reset();
    set_lane(0, 4'd5, 32'hDEAD_BEEF);
    req = 4'b0001;
    #1;
    n_vec++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL single_gnt: got %b expected 0001", gnt); end
    @(posedge clk); #1;
    req = '0;
    n_vec++; if (wr_en !== 1'b1) begin n_err++; $display("FAIL single_wr_en: got %0b expected 1", wr_en); end
    n_vec++; if (wr_sel !== 4'd5) begin n_err++; $display("FAIL single_wr_sel: got %0d expected 5", wr_sel); end
    n_vec++; if (wr_data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL single_wr_data: got %0h expected deadbeef", wr_data); end
    #1;
    n_vec++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL single_idle_gnt: got %b expected 0000", gnt); end
    @(posedge clk); #1;
    n_vec++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL single_idle_en: got %0b expected 0", wr_en); end
    n_vec++; if (wr_sel !== 4'd5) begin n_err++; $display("FAIL single_hold_sel: got %0d expected 5", wr_sel); end
    n_vec++; if (wr_data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL single_hold_data: got %0h expected deadbeef", wr_data); end
  endtask

  task automatic test_round_robin();
    logic [3:0] eg;
    do_reset();
    for (int i = 0; i < 4; i++) set_lane(i, 4'(i + 8), 32'h1000 + 32'(i));
    req = 4'hF;
    for (int c = 0; c < 8; c++) begin
      eg = 4'b0001 << (c % 4);
      #1;
      n_vec++; if (gnt !== eg) begin n_err++; $display("FAIL rr_gnt[%0d]: got %b expected %b", c, gnt, eg); end
      @(posedge clk); #1;
      n_vec++; if (wr_sel !== 4'((c % 4) + 8)) begin n_err++; $display("FAIL rr_sel[%0d]: got %0d expected %0d", c, wr_sel, (c % 4) + 8); end
      n_vec++; if (wr_data !== 32'h1000 + 32'(c % 4)) begin n_err++; $display("FAIL rr_data[%0d]: got %0h expected %0h", c, wr_data, 32'h1000 + 32'(c % 4)); end
    end
    req = '0;
  endtask

  // Entered with ptr = 0 (after eight rotating grants).
  task automatic test_skip();
    set_lane(1, 4'd3, 32'h0000_0011);
    req = 4'b0010;
    #1;
    n_vec++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL skip_setup_gnt: got %b expected 0010", gnt); end
    @(posedge clk); #1;  // ptr -> 2
    set_lane(3, 4'd12, 32'h0000_0033);
    req = 4'b1010;
    #1;
    n_vec++; if (gnt !== 4'b1000) begin n_err++; $display("FAIL skip_gnt_p2: got %b expected 1000", gnt); end
    @(posedge clk); #1;  // ptr -> 0
    n_vec++; if (wr_sel !== 4'd12) begin n_err++; $display("FAIL skip_sel3: got %0d expected 12", wr_sel); end
    n_vec++; if (wr_data !== 32'h33) begin n_err++; $display("FAIL skip_data3: got %0h expected 33", wr_data); end
    #1;
    n_vec++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL skip_gnt_p0: got %b expected 0010", gnt); end
    @(posedge clk); #1;  // ptr -> 2
    n_vec++; if (wr_sel !== 4'd3) begin n_err++; $display("FAIL skip_sel1: got %0d expected 3", wr_sel); end
    req = '0;  // withdrawal: no transfer, ptr holds
    #1;
    n_vec++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL wd_gnt: got %b expected 0000", gnt); end
    @(posedge clk); #1;
    n_vec++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL wd_wr_en: got %0b expected 0", wr_en); end
    set_lane(0, 4'd7, 32'h0000_0007);
    req = 4'b1001;
    #1;
    n_vec++; if (gnt !== 4'b1000) begin n_err++; $display("FAIL wd_hold_ptr_gnt: got %b expected 1000", gnt); end
    @(posedge clk); #1;
    req = '0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      set_lane(2, 4'(c + 1), 32'hB000 + 32'(c));
      req = 4'b0100;
      #1;
      n_vec++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL b2b_gnt[%0d]: got %b expected 0100", c, gnt); end
      @(posedge clk); #1;
      n_vec++; if (wr_en !== 1'b1) begin n_err++; $display("FAIL b2b_en[%0d]: got %0b expected 1", c, wr_en); end
      n_vec++; if (wr_sel !== 4'(c + 1)) begin n_err++; $display("FAIL b2b_sel[%0d]: got %0d expected %0d", c, wr_sel, c + 1); end
      n_vec++; if (wr_data !== 32'hB000 + 32'(c)) begin n_err++; $display("FAIL b2b_data[%0d]: got %0h expected %0h", c, wr_data, 32'hB000 + 32'(c)); end
    end
    req = '0;
  endtask

  initial begin
    test_reset();
`ifdef REGFILE_WR_ARB_INIT_EN
    test_init_seq();
    test_reset_mid_init();
`endif
    test_first_cycle();
    test_single();
    test_round_robin();
    test_skip();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
